bk_cmd_sequencer: RTL and testbench
===================================

Name: bk_cmd_sequencer

Overview:
Host-side initiator for the bk processor datapath.
- Accepts command/operand transactions over a valid/ready request interface and buffers them in a small FIFO.
- Drives the processor's command and data inputs, waits a fixed response latency, and captures the result and flags.
- Returns the captured result over a valid/ready response interface.
- Sits between a test or host controller and the processor top; it is the issuing end of the processor's cmd/din/dout interface.

Parameters:
WIDTH, 8, operand width; result width is 2*WIDTH
CMD_W, 7, command field width
FIFO_DEPTH, 4, request FIFO entries (power of 2, >=2)
RESP_LATENCY, 4, cycles from command issue to valid processor outputs (>=1)
NOP_CMD, 0, command value driven when no command is being issued

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  FIFO can accept a request
req_cmd  in  CMD_W  command to issue
req_d1  in  WIDTH  operand 1 (also the memory address)
req_d2  in  WIDTH  operand 2
req_d3  in  WIDTH  operand 3
proc_cmd  out  CMD_W  to processor cmdin
proc_d1  out  WIDTH  to processor din_1
proc_d2  out  WIDTH  to processor din_2
proc_d3  out  WIDTH  to processor din_3
proc_dout_low  in  WIDTH  from processor
proc_dout_high  in  WIDTH  from processor
proc_zero  in  1  from processor
proc_error  in  1  from processor
resp_valid  out  1  response available
resp_ready  in  1  consumer accepts response
resp_data  out  2*WIDTH  {dout_high, dout_low} captured
resp_zero  out  1  captured zero flag
resp_error  out  1  captured error flag
busy  out  1  state != IDLE or FIFO not empty
err_count  out  8  saturating count of responses with error=1

Behaviour:
- Reset (async, any state): FIFO empty; state=IDLE.
  - Outputs: req_ready=1, proc_cmd=NOP_CMD, proc_d1..3=0, resp_valid=0, resp_data=0, resp_zero=0, resp_error=0, err_count=0, busy=0.
  - Any in-flight transaction is discarded; no response is produced for it.
- Request FIFO:
  - req_ready = !full.
  - Push occurs on req_valid&&req_ready.
  - Push and pop in the same cycle when full: req_ready stays 0 that cycle. There is no combinational ready-from-pop path.
  - Push and pop in the same cycle when empty is not possible; a pop requires a registered entry.
  - Order is FIFO; pointers wrap modulo FIFO_DEPTH.
- FSM states: IDLE, ISSUE, WAIT, RESP.
  - IDLE: if FIFO non-empty, pop the head and register it into the proc_d1..3 drive regs and a pending cmd reg, then go to ISSUE. Otherwise stay.
  - ISSUE (1 cycle): proc_cmd=pending cmd. Load lat_cnt=RESP_LATENCY-1, then go to WAIT.
  - WAIT: proc_cmd=NOP_CMD; proc_d1..3 stay held. While lat_cnt!=0, decrement. When lat_cnt==0, capture resp_data={proc_dout_high,proc_dout_low}, resp_zero and resp_error, set resp_valid=1, and go to RESP.
  - RESP: resp_valid=1 and resp_* are held stable until resp_ready. On resp_valid&&resp_ready: resp_valid=0, go to IDLE. proc_d1..3 stay held until the next pop.
- Latency: first proc_cmd cycle is 2 cycles after the push edge (IDLE pop, then ISSUE). resp_valid rises RESP_LATENCY cycles after the ISSUE cycle. Back-to-back throughput is one transaction per RESP_LATENCY+3 cycles with resp_ready tied high.
- err_count: increments on each capture with proc_error=1 and saturates at 255.
- New requests are accepted in every state while the FIFO is not full.
- Backpressure: resp_ready low holds the FSM in RESP. The FIFO keeps filling until full.
- No X propagation: all registered outputs have defined reset values.

Test Plan:
1. Single transaction, RESP_LATENCY=4: push cmd=7'h05, d1=8'h03, d2=8'h0A, d3=0; model returns 16'h001E, zero=0 -> proc_cmd=05 for exactly 1 cycle (2 cycles after the push); resp_valid 4 cycles later with resp_data=16'h001E, zero=0, error=0.
2. FIFO full: hold resp_ready=0 and push 6 requests -> 4 accepted into the FIFO plus 1 in flight; req_ready=0 after the FIFO fills; release resp_ready -> responses return in push order, 5 total.
3. Backpressure: resp_ready=0 for 10 cycles in RESP -> resp_valid, resp_data and resp flags stay stable; proc_cmd=NOP_CMD throughout; next issue occurs only after the handshake.
4. Error count: 3 transactions with proc_error=1,0,1 -> err_count=2 and resp_error per response =1,0,1; preload 255 errors -> err_count holds 255.
5. Reset mid-WAIT: assert rst asynchronously between clock edges -> all outputs go to reset values immediately, FIFO empties, req_ready=1, and no response is produced for the aborted command.
6. Zero flag: model returns 16'h0000 with zero=1 -> resp_zero=1 and resp_data=0.

Source files
------------

// File: rtl/bk_cmd_sequencer.sv
// bk_cmd_sequencer: host-side initiator for the bk processor datapath.
// Buffers requests in a FIFO, issues them to the processor, waits a fixed
// latency, captures {dout_high, dout_low} and flags, returns them as a
// valid/ready response.
// Ports:
//   clk, rst             clock, async active-high reset
//   req_valid/ready      request handshake; req_cmd, req_d1..3 payload
//   proc_cmd, proc_d1..3 drive to processor cmdin / din_1..3
//   proc_dout_low/high   result from processor; proc_zero, proc_error flags
//   resp_valid/ready     response handshake; resp_data, resp_zero, resp_error
//   busy                 FSM not idle or FIFO not empty
//   err_count            saturating count of captured error responses
module bk_cmd_sequencer #(
  parameter int WIDTH        = 8,
  parameter int CMD_W        = 7,
  parameter int FIFO_DEPTH   = 4,
  parameter int RESP_LATENCY = 4,
  parameter logic [CMD_W-1:0] NOP_CMD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_valid,
  output logic               req_ready,
  input  logic [CMD_W-1:0]   req_cmd,
  input  logic [WIDTH-1:0]   req_d1,
  input  logic [WIDTH-1:0]   req_d2,
  input  logic [WIDTH-1:0]   req_d3,
  output logic [CMD_W-1:0]   proc_cmd,
  output logic [WIDTH-1:0]   proc_d1,
  output logic [WIDTH-1:0]   proc_d2,
  output logic [WIDTH-1:0]   proc_d3,
  input  logic [WIDTH-1:0]   proc_dout_low,
  input  logic [WIDTH-1:0]   proc_dout_high,
  input  logic               proc_zero,
  input  logic               proc_error,
  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [2*WIDTH-1:0] resp_data,
  output logic               resp_zero,
  output logic               resp_error,
  output logic               busy,
  output logic [7:0]         err_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = $clog2(RESP_LATENCY + 1);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(FIFO_DEPTH);
  localparam logic [LW-1:0] LAT_LOAD = LW'(RESP_LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  typedef struct packed {
    logic [CMD_W-1:0] cmd;
    logic [WIDTH-1:0] d1;
    logic [WIDTH-1:0] d2;
    logic [WIDTH-1:0] d3;
  } reqEntry_t;

  state_t           state;
  state_t           stateNext;
  reqEntry_t        fifoMem [FIFO_DEPTH];
  reqEntry_t        headEntry;
  logic [PW-1:0]    wrPtr;
  logic [PW-1:0]    rdPtr;
  logic [PW:0]      fifoCount;
  logic             fifoEmpty;
  logic             fifoFull;
  logic             doPush;
  logic             doPop;
  logic             doCapture;
  logic [CMD_W-1:0] pendCmd;
  logic [LW-1:0]    latCnt;

  assign fifoEmpty = (fifoCount == '0);
  assign fifoFull  = (fifoCount == FULL_CNT);
  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign req_ready = !fifoFull;
  assign doPush    = req_valid && !fifoFull;
  assign doPop     = (state == IDLE) && !fifoEmpty;
  assign doCapture = (state == WAIT) && (latCnt == '0);
  assign headEntry = fifoMem[rdPtr];
  assign busy      = (state != IDLE) || !fifoEmpty;

  always_ff @(posedge clk) begin
    if (doPush) begin
      fifoMem[wrPtr] <= {req_cmd, req_d1, req_d2, req_d3};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
    end else begin
      if (doPush) begin
        wrPtr <= wrPtr + PW'(1);
      end
      if (doPop) begin
        rdPtr <= rdPtr + PW'(1);
      end
      unique case ({doPush, doPop})
        2'b10:   fifoCount <= fifoCount + (PW+1)'(1);
        2'b01:   fifoCount <= fifoCount - (PW+1)'(1);
        default: fifoCount <= fifoCount;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    proc_cmd  = NOP_CMD;
    unique case (state)
      IDLE: begin
        if (!fifoEmpty) begin
          stateNext = ISSUE;
        end
      end
      ISSUE: begin
        proc_cmd  = pendCmd;
        stateNext = WAIT;
      end
      WAIT: begin
        if (latCnt == '0) begin
          stateNext = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          stateNext = IDLE;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pendCmd    <= NOP_CMD;
      proc_d1    <= '0;
      proc_d2    <= '0;
      proc_d3    <= '0;
      latCnt     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_zero  <= 1'b0;
      resp_error <= 1'b0;
      err_count  <= '0;
    end else begin
      // Operands stay on the bus until the next pop.
      if (doPop) begin
        pendCmd <= headEntry.cmd;
        proc_d1 <= headEntry.d1;
        proc_d2 <= headEntry.d2;
        proc_d3 <= headEntry.d3;
      end
      if (state == ISSUE) begin
        latCnt <= LAT_LOAD;
      end else if ((state == WAIT) && (latCnt != '0)) begin
        latCnt <= latCnt - LW'(1);
      end
      if (doCapture) begin
        resp_valid <= 1'b1;
        resp_data  <= {proc_dout_high, proc_dout_low};
        resp_zero  <= proc_zero;
        resp_error <= proc_error;
        if (proc_error && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end else if ((state == RESP) && resp_ready) begin
        resp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bk_cmd_sequencer.sv
// tb_bk_cmd_sequencer: directed table, corner sequences and random traffic
// against a transaction-level scoreboard and a latency-accurate processor.
module tb_bk_cmd_sequencer;

  localparam int LAT = 4;
  localparam logic [6:0] NOP = 7'h00;

  typedef struct {
    logic [15:0] data;
    logic        zero;
    logic        err;
  } exp_t;

  typedef struct {
    logic [6:0]  cmd;
    logic [7:0]  d1;
    logic [7:0]  d2;
    logic [7:0]  d3;
    logic [15:0] data;
    logic        zero;
    logic        err;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [6:0]  req_cmd = '0;
  logic [7:0]  req_d1 = '0;
  logic [7:0]  req_d2 = '0;
  logic [7:0]  req_d3 = '0;
  logic [6:0]  proc_cmd;
  logic [7:0]  proc_d1;
  logic [7:0]  proc_d2;
  logic [7:0]  proc_d3;
  logic [7:0]  proc_dout_low;
  logic [7:0]  proc_dout_high;
  logic        proc_zero;
  logic        proc_error;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [15:0] resp_data;
  logic        resp_zero;
  logic        resp_error;
  logic        busy;
  logic [7:0]  err_count;

  int checks = 0;
  int failures = 0;
  int respSeen = 0;
  int errModel = 0;
  logic lastAcc = 1'b0;
  exp_t expQ[$];
  logic [6:0] issueQ[$];
  vec_t tbl[6];

  bk_cmd_sequencer dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_d1(req_d1), .req_d2(req_d2), .req_d3(req_d3),
    .proc_cmd(proc_cmd), .proc_d1(proc_d1), .proc_d2(proc_d2),
    .proc_d3(proc_d3),
    .proc_dout_low(proc_dout_low), .proc_dout_high(proc_dout_high),
    .proc_zero(proc_zero), .proc_error(proc_error),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_data(resp_data), .resp_zero(resp_zero), .resp_error(resp_error),
    .busy(busy), .err_count(err_count)
  );

  always #5 clk = ~clk;

  // Processor result: d1*d2+d3, error when cmd bit 6 is set.
  function automatic exp_t refModel(input logic [6:0] c,
                                    input logic [7:0] a,
                                    input logic [7:0] b,
                                    input logic [7:0] d);
    exp_t r;
    logic [15:0] p;
    p = 16'(a) * 16'(b) + 16'(d);
    r.data = p;
    r.zero = (p == 16'h0000);
    r.err  = c[6];
    return r;
  endfunction

  // Processor: outputs valid only LAT cycles after sampling a command,
  // junk otherwise.
  logic [6:0] pmCmd = '0;
  logic [7:0] pmA = '0;
  logic [7:0] pmB = '0;
  logic [7:0] pmC = '0;
  int pmAge = 0;
  exp_t pmRes;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pmAge <= 0;
    end else if (proc_cmd != NOP) begin
      pmCmd <= proc_cmd;
      pmA   <= proc_d1;
      pmB   <= proc_d2;
      pmC   <= proc_d3;
      pmAge <= 1;
    end else if (pmAge != 0 && pmAge < 100) begin
      pmAge <= pmAge + 1;
    end
  end

  always_comb pmRes = refModel(pmCmd, pmA, pmB, pmC);
  assign proc_dout_low  = (pmAge == LAT) ? pmRes.data[7:0] : 8'hA5;
  assign proc_dout_high = (pmAge == LAT) ? pmRes.data[15:8] : 8'h5A;
  assign proc_zero      = (pmAge == LAT) && pmRes.zero;
  assign proc_error     = (pmAge == LAT) && pmRes.err;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Bookkeeping on values settled at this negedge, then advance one cycle.
  task automatic tick();
    exp_t e;
    lastAcc = 1'b0;
    if (proc_cmd != NOP) begin
      if (issueQ.size() == 0) begin
        chk("spurious_issue", 32'(proc_cmd), 32'(NOP));
      end else begin
        chk("issue_order", 32'(proc_cmd), 32'(issueQ.pop_front()));
      end
    end
    if (resp_valid && resp_ready) begin
      respSeen++;
      if (expQ.size() == 0) begin
        chk("spurious_resp", 32'(resp_valid), 32'd0);
      end else begin
        e = expQ.pop_front();
        chk("resp_data", 32'(resp_data), 32'(e.data));
        chk("resp_zero", 32'(resp_zero), 32'(e.zero));
        chk("resp_error", 32'(resp_error), 32'(e.err));
        if (e.err && errModel < 255) errModel++;
        chk("err_count", 32'(err_count), 32'(errModel));
      end
    end
    if (req_valid && req_ready) begin
      lastAcc = 1'b1;
      expQ.push_back(refModel(req_cmd, req_d1, req_d2, req_d3));
      issueQ.push_back(req_cmd);
    end
    @(negedge clk);
  endtask

  task automatic pushOne(input logic [6:0] c, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] d);
    int n = 0;
    req_cmd = c;
    req_d1 = a;
    req_d2 = b;
    req_d3 = d;
    req_valid = 1'b1;
    tick();
    while (!lastAcc && n < 100) begin
      tick();
      n++;
    end
    chk("push_accept", 32'(lastAcc), 32'd1);
    req_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((busy || resp_valid) && n < 300) begin
      tick();
      n++;
    end
    chk("drain_timeout", 32'(busy || resp_valid), 32'd0);
    chk("queue_empty", 32'(expQ.size()), 32'd0);
  endtask

  task automatic checkReset(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_proc_cmd"}, 32'(proc_cmd), 32'(NOP));
    chk({tag, "_proc_d"}, 32'({proc_d1, proc_d2, proc_d3}), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_resp_data"}, 32'(resp_data), 32'd0);
    chk({tag, "_resp_flags"}, 32'({resp_zero, resp_error}), 32'd0);
    chk({tag, "_err_count"}, 32'(err_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int n;
    int acc;
    int sent;
    int cyc;
    tbl[0] = '{7'h05, 8'h03, 8'h0A, 8'h00, 16'h001E, 1'b0, 1'b0};
    tbl[1] = '{7'h45, 8'h02, 8'h03, 8'h01, 16'h0007, 1'b0, 1'b1};
    tbl[2] = '{7'h05, 8'h04, 8'h04, 8'h00, 16'h0010, 1'b0, 1'b0};
    tbl[3] = '{7'h41, 8'h10, 8'h10, 8'h00, 16'h0100, 1'b0, 1'b1};
    tbl[4] = '{7'h05, 8'h00, 8'h55, 8'h00, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{7'h12, 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 1'b0, 1'b0};

    #1 rst = 1'b1;
    #2 checkReset("reset");
    @(negedge clk);
    rst = 1'b0;

    // Directed vectors with exact issue and response timing.
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      chk("tbl_req_ready", 32'(req_ready), 32'd1);
      pushOne(tbl[i].cmd, tbl[i].d1, tbl[i].d2, tbl[i].d3);
      chk("tbl_pre_issue_nop", 32'(proc_cmd), 32'(NOP));
      tick();
      chk("tbl_issue_cmd", 32'(proc_cmd), 32'(tbl[i].cmd));
      chk("tbl_issue_d", 32'({proc_d1, proc_d2, proc_d3}),
          32'({tbl[i].d1, tbl[i].d2, tbl[i].d3}));
      tick();
      chk("tbl_issue_one_cycle", 32'(proc_cmd), 32'(NOP));
      n = 0;
      while (!resp_valid && n < 20) begin
        tick();
        n++;
      end
      chk("tbl_resp_latency", 32'(n), 32'(LAT));
      chk("tbl_resp_data", 32'(resp_data), 32'(tbl[i].data));
      chk("tbl_resp_zero", 32'(resp_zero), 32'(tbl[i].zero));
      chk("tbl_resp_error", 32'(resp_error), 32'(tbl[i].err));
      tick();
      chk("tbl_resp_dropped", 32'(resp_valid), 32'd0);
      chk("tbl_idle", 32'(busy), 32'd0);
    end
    chk("tbl_err_count", 32'(err_count), 32'd2);

    // FIFO full under backpressure: 5 accepted of 6 offered.
    resp_ready = 1'b0;
    acc = 0;
    for (int i = 0; i < 12; i++) begin
      if (!req_valid) begin
        req_cmd = 7'(1 + $urandom_range(126));
        req_d1 = 8'($urandom);
        req_d2 = 8'($urandom);
        req_d3 = 8'($urandom);
        req_valid = 1'b1;
      end
      tick();
      if (lastAcc) begin
        acc++;
        req_valid = 1'b0;
      end
    end
    chk("full_accepted", 32'(acc), 32'd5);
    chk("full_req_ready", 32'(req_ready), 32'd0);
    chk("full_busy", 32'(busy), 32'd1);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    respSeen = 0;
    drain();
    chk("full_resp_count", 32'(respSeen), 32'd5);

    // Response held stable for 10 cycles; next command waits.
    resp_ready = 1'b0;
    pushOne(7'h05, 8'h07, 8'h06, 8'h01);
    pushOne(7'h09, 8'h01, 8'h01, 8'h00);
    n = 0;
    while (!resp_valid && n < 20) begin
      tick();
      n++;
    end
    chk("bp_resp_seen", 32'(resp_valid), 32'd1);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(resp_valid), 32'd1);
      chk("bp_data", 32'(resp_data), 32'h002B);
      chk("bp_flags", 32'({resp_zero, resp_error}), 32'd0);
      chk("bp_nop", 32'(proc_cmd), 32'(NOP));
      tick();
    end
    resp_ready = 1'b1;
    tick();
    chk("bp_idle_nop", 32'(proc_cmd), 32'(NOP));
    tick();
    chk("bp_next_issue", 32'(proc_cmd), 32'h09);
    drain();

    // err_count saturates at 255.
    for (int i = 0; i < 260; i++) begin
      pushOne(7'h40 | 7'(i % 63 + 1), 8'($urandom), 8'($urandom), 8'h00);
    end
    drain();
    chk("sat_err_count", 32'(err_count), 32'd255);

    // Asynchronous reset in WAIT with more work queued.
    pushOne(7'h05, 8'h02, 8'h02, 8'h00);
    pushOne(7'h06, 8'h03, 8'h03, 8'h00);
    pushOne(7'h07, 8'h04, 8'h04, 8'h00);
    tick();
    #2 rst = 1'b1;
    #1 checkReset("mid_wait_reset");
    expQ.delete();
    issueQ.delete();
    errModel = 0;
    @(negedge clk);
    rst = 1'b0;
    respSeen = 0;
    for (int i = 0; i < 12; i++) begin
      chk("abort_no_valid", 32'(resp_valid), 32'd0);
      tick();
    end
    chk("abort_resp_count", 32'(respSeen), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);

    // Random traffic with random backpressure.
    sent = 0;
    cyc = 0;
    while (sent < 200 && cyc < 20000) begin
      if (!req_valid && $urandom_range(3) != 0) begin
        req_cmd = 7'(1 + $urandom_range(126));
        req_d1 = 8'($urandom);
        req_d2 = 8'($urandom);
        req_d3 = 8'($urandom);
        req_valid = 1'b1;
      end
      resp_ready = ($urandom_range(2) != 0);
      tick();
      cyc++;
      if (lastAcc) begin
        sent++;
        req_valid = 1'b0;
      end
    end
    chk("rand_sent", 32'(sent), 32'd200);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
